// File: rtl/cpu1_fetch_if.sv
// cpu1_fetch bus bundle: instruction-memory read port, execute-side
// stall/redirect controls and the instruction-register load pair.
// master = fetch stage, slave = memory/downstream environment.
interface cpu1_fetch_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_wait;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          ir_cen;
    logic [DW-1:0] ir_din;
    logic [AW-1:0] pc_out;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_wait,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output ir_cen,
        output ir_din,
        output pc_out
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_wait,
        output stall,
        output redirect,
        output redirect_pc,
        input  ir_cen,
        input  ir_din,
        input  pc_out
    );
endinterface

// File: rtl/cpu1_fetch.sv
// cpu1 instruction fetch stage: reads one word per instruction through a
// wait-state handshake, buffers it and pulses ir_cen once per word.
// Branch redirects from execute override everything except reset.
// Optional overlap of the next read with delivery: CPU1_FETCH_PREFETCH_EN.
module cpu1_fetch #(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    cpu1_fetch_if.master  bus
);
    typedef enum logic {
        FETCH   = 1'b0,
        DELIVER = 1'b1
    } state_t;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] buf_pc, buf_pc_nxt;
    logic [DW-1:0] ibuf, ibuf_nxt;
    logic          rd;
    logic          cen;

    // Next-state, buffer load and handshake outputs; redirect beats every state.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        buf_pc_nxt = buf_pc;
        ibuf_nxt   = ibuf;
        rd         = 1'b0;
        cen        = 1'b0;
        if (reset) begin
            rd  = 1'b0;
            cen = 1'b0;
        end else if (bus.redirect) begin
            pc_nxt    = bus.redirect_pc;
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    rd = 1'b1;
                    if (!bus.mem_wait) begin
                        ibuf_nxt   = bus.mem_rdata;
                        buf_pc_nxt = pc;
                        pc_nxt     = pc + PC_ONE;
                        state_nxt  = DELIVER;
                    end
                end
                DELIVER: begin
                    cen = !bus.stall;
`ifdef CPU1_FETCH_PREFETCH_EN
                    // Overlapped read: a completion here refills the buffer in
                    // the same cycle the current word is consumed.
                    rd = !bus.stall;
                    if (!bus.stall && !bus.mem_wait) begin
                        ibuf_nxt   = bus.mem_rdata;
                        buf_pc_nxt = pc;
                        pc_nxt     = pc + PC_ONE;
                    end else if (!bus.stall) begin
                        state_nxt = FETCH;
                    end
`else
                    if (!bus.stall) begin
                        state_nxt = FETCH;
                    end
`endif
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // State, PC and instruction buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            buf_pc <= RESET_PC;
            ibuf   <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            buf_pc <= buf_pc_nxt;
            ibuf   <= ibuf_nxt;
        end
    end

    // Registered values are masked while reset is high so the reset-value
    // outputs hold from the very first reset cycle.
    assign bus.mem_rd   = rd;
    assign bus.ir_cen   = cen;
    assign bus.mem_addr = reset ? RESET_PC : pc;
    assign bus.ir_din   = reset ? '0 : ibuf;
    assign bus.pc_out   = reset ? RESET_PC : buf_pc;
endmodule

// File: tb/tb_cpu1_fetch.sv
// Self-checking bench for cpu1_fetch (default build, no prefetch).
// A per-cycle trace table plus hand-written reset sequences; every ir_cen
// pulse is checked against a scoreboard queue of expected fetch addresses.
module tb_cpu1_fetch;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    cpu1_fetch_if #(.AW(32), .DW(32)) bus ();

    cpu1_fetch #(.AW(32), .DW(32), .RESET_PC(32'h100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Zero-latency memory model: each word holds its address xor K.
    assign bus.mem_rdata = bus.mem_addr ^ K;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        mw;
        logic        rd;
        logic [31:0] rpc;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_cen;
        logic [31:0] e_pcout;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, then score any
    // delivered instruction against the head of the expected queue.
    task automatic cycle(input logic rst, input logic st, input logic mw,
                         input logic rd, input logic [31:0] rpc);
        logic [31:0] e;
        @(negedge clk);
        reset           = rst;
        bus.stall       = st;
        bus.mem_wait    = mw;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #1;
        if (bus.ir_cen === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ir_cen", bus.pc_out, 32'hxxxxxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc_out", bus.pc_out, e);
                chk("sb_ir_din", bus.ir_din, e ^ K);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_rd"},   {31'd0, bus.mem_rd}, 32'd0);
        chk({tag, "_ir_cen"},   {31'd0, bus.ir_cen}, 32'd0);
        chk({tag, "_ir_din"},   bus.ir_din, 32'd0);
        chk({tag, "_pc_out"},   bus.pc_out, 32'h100);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h100);
    endtask

    function automatic vec_t v(input logic st, input logic mw, input logic rd,
                               input logic [31:0] rpc, input logic e_rd,
                               input logic [31:0] e_addr, input logic e_cen,
                               input logic [31:0] e_pcout);
        vec_t r;
        r.st = st; r.mw = mw; r.rd = rd; r.rpc = rpc;
        r.e_rd = e_rd; r.e_addr = e_addr; r.e_cen = e_cen; r.e_pcout = e_pcout;
        return r;
    endfunction

    initial begin
        int last_cen;
        int gap_ok;
        int n;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.mem_wait = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        //        st mw rd rpc            e_rd e_addr        cen pc_out
        tbl[0]  = v(0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h100);
        tbl[1]  = v(0, 0, 0, 32'h0,        0, 32'h101,      1, 32'h100);
        tbl[2]  = v(0, 1, 0, 32'h0,        1, 32'h101,      0, 32'h100);
        tbl[3]  = v(0, 1, 0, 32'h0,        1, 32'h101,      0, 32'h100);
        tbl[4]  = v(0, 1, 0, 32'h0,        1, 32'h101,      0, 32'h100);
        tbl[5]  = v(0, 0, 0, 32'h0,        1, 32'h101,      0, 32'h100);
        tbl[6]  = v(0, 0, 0, 32'h0,        0, 32'h102,      1, 32'h101);
        tbl[7]  = v(0, 0, 0, 32'h0,        1, 32'h102,      0, 32'h101);
        tbl[8]  = v(1, 0, 0, 32'h0,        0, 32'h103,      0, 32'h102);
        tbl[9]  = v(1, 0, 0, 32'h0,        0, 32'h103,      0, 32'h102);
        tbl[10] = v(1, 0, 0, 32'h0,        0, 32'h103,      0, 32'h102);
        tbl[11] = v(1, 0, 0, 32'h0,        0, 32'h103,      0, 32'h102);
        tbl[12] = v(1, 0, 0, 32'h0,        0, 32'h103,      0, 32'h102);
        tbl[13] = v(0, 0, 0, 32'h0,        0, 32'h103,      1, 32'h102);
        tbl[14] = v(0, 1, 1, 32'h200,      0, 32'h103,      0, 32'h102);
        tbl[15] = v(0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h102);
        tbl[16] = v(0, 0, 0, 32'h0,        0, 32'h201,      1, 32'h200);
        tbl[17] = v(0, 0, 0, 32'h0,        1, 32'h201,      0, 32'h200);
        tbl[18] = v(1, 0, 1, 32'h200,      0, 32'h202,      0, 32'h201);
        tbl[19] = v(0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h201);
        tbl[20] = v(0, 0, 0, 32'h0,        0, 32'h201,      1, 32'h200);
        tbl[21] = v(0, 0, 1, 32'hFFFFFFFF, 0, 32'h201,      0, 32'h200);
        tbl[22] = v(0, 0, 0, 32'h0,        1, 32'hFFFFFFFF, 0, 32'h200);
        tbl[23] = v(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFF);
        tbl[24] = v(0, 0, 0, 32'h0,        1, 32'h0,        0, 32'hFFFFFFFF);
        tbl[25] = v(0, 0, 0, 32'h0,        0, 32'h1,        1, 32'h0);

        // 0x201 is buffered at row 17 but discarded by the stalled redirect.
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h200, 32'h200, 32'hFFFFFFFF, 32'h0};

        cycle(1, 0, 0, 0, 0);
        chk_reset_outputs("rst0");
        cycle(1, 0, 0, 0, 0);
        chk_reset_outputs("rst1");

        for (int i = 0; i < 26; i++) begin
            cycle(0, tbl[i].st, tbl[i].mw, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("r%0d_mem_rd", i), {31'd0, bus.mem_rd}, {31'd0, tbl[i].e_rd});
            chk($sformatf("r%0d_mem_addr", i), bus.mem_addr, tbl[i].e_addr);
            chk($sformatf("r%0d_ir_cen", i), {31'd0, bus.ir_cen}, {31'd0, tbl[i].e_cen});
            chk($sformatf("r%0d_pc_out", i), bus.pc_out, tbl[i].e_pcout);
            chk($sformatf("r%0d_ir_din", i), bus.ir_din, (i == 0) ? 32'h0 : (tbl[i].e_pcout ^ K));
        end
        chk("table_queue_left", exp_q.size(), 0);

        // Reset in the middle of a waiting read.
        cycle(0, 0, 1, 0, 0);
        chk("midwait_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("midwait_mem_addr", bus.mem_addr, 32'h1);
        cycle(1, 0, 1, 0, 0);
        chk_reset_outputs("rstwait_a");
        cycle(1, 0, 1, 0, 0);
        chk_reset_outputs("rstwait_b");

        // Restart at RESET_PC, then reset while a word waits in DELIVER.
        exp_q.push_back(32'h100);
        cycle(0, 1, 0, 0, 0);
        chk("restart_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("restart_mem_addr", bus.mem_addr, 32'h100);
        cycle(0, 1, 0, 0, 0);
        chk("deliver_stall_cen", {31'd0, bus.ir_cen}, 32'd0);
        chk("deliver_stall_pc_out", bus.pc_out, 32'h100);
        cycle(1, 1, 0, 0, 0);
        chk_reset_outputs("rstdeliver");

        // Free run at zero wait: 0x100..0x102, one pulse every second cycle.
        exp_q.push_back(32'h101);
        exp_q.push_back(32'h102);
        last_cen = -1;
        gap_ok = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cycle(0, 0, 0, 0, 0);
            if (bus.ir_cen === 1'b1) begin
                if (last_cen >= 0 && (n - last_cen) != 2) gap_ok = 0;
                last_cen = n;
            end
            n++;
        end
        chk("freerun_drained", exp_q.size(), 0);
        chk("freerun_every_2nd_cycle", gap_ok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
